risc_core_param: RTL and testbench
==================================

RISC_CORE_PARAM -- requirements
Module: risc_core_param

Interface
REQ-001 Parameter DATA_W, default 16, datapath, register and instruction width; legal range 16..32.
REQ-002 Parameter ADDR_W, default 16, memory address and PC width.
REQ-003 Parameter REG_ADR_W, default 3, register-select width; 2**REG_ADR_W registers; 4+3*REG_ADR_W <= DATA_W.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 D_in  in  DATA_W  read data, valid when mem_ready=1 on a read.
REQ-007 mem_ready  in  1  memory completes current request on the edge where mem_req=1 and mem_ready=1.
REQ-008 mem_req  out  1  memory request pending.
REQ-009 mw_en  out  1  write qualifier for current request.
REQ-010 Address  out  ADDR_W  request address.
REQ-011 D_out  out  DATA_W  write data.
REQ-012 status  out  8  {state[2:0], mem_req, V, N, Z, C}.
REQ-013 halted  out  1  high while in HALTED.

Function
REQ-014 Instruction: op = IR[DATA_W-1 -: 4]; W, R, S = consecutive REG_ADR_W fields directly below op, W highest.
REQ-015 Ops: 0 NOP; 1 ADD W=R+S; 2 SUB W=R-S; 3 AND; 4 OR; 5 XOR; 6 SHL W=S<<1; 7 SHR W=S>>1 (logical); 8 LD W=M[R]; 9 ST M[R]=S; A LDI W=M[PC]; B JMP; C JZ; D JN; E JC (target = M[PC]); F HALT.
REQ-016 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, HALTED=4; other codes unreachable.
REQ-017 FETCH: mem_req=1, mw_en=0, Address=PC; on completion IR<=D_in, PC<=PC+1, ->DECODE.
REQ-018 DECODE: ops 0-7 ->EXEC; 8,9,A,B, and C/D/E with condition true ->MEM; C/D/E false ->EXEC; F ->HALTED.
REQ-019 EXEC: ALU ops write W and flags; untaken jump PC<=PC+1 (skip operand); NOP no effect; ->FETCH.
REQ-020 MEM: mem_req=1; LD Address=R[ADDR_W-1:0] (zero-extended if DATA_W<ADDR_W); ST Address=R, D_out=S, mw_en=1; LDI/jumps Address=PC; on completion LD/LDI write W, LDI PC<=PC+1, jump PC<=D_in[ADDR_W-1:0]; ->FETCH.
REQ-021 Address, D_out, mw_en SHALL be stable while mem_req=1 and mem_ready=0; mem_req=0 in DECODE, EXEC, HALTED.
REQ-022 Zero-wait (mem_ready tied 1): every non-HALT instruction takes exactly 3 cycles.
REQ-023 Flags: N=result MSB, Z=(result==0) for ops 1-7; ADD C=carry out; SUB C=1 when R>=S unsigned (no borrow); logic ops C=0, V=0; shifts C=bit shifted out, V=0; ADD/SUB V=signed overflow; ops 0,8-F leave flags.
REQ-024 Arithmetic modulo 2**DATA_W; PC wraps from 2**ADDR_W-1 to 0.
REQ-025 W==R or W==S reads pre-write values; register 0 is general-purpose (not hardwired).
REQ-026 HALTED: no requests; remains until rst.

Reset
REQ-027 rst=1 at an edge: state=FETCH, PC=0, IR=0, all registers 0, flags 0; any pending request abandoned, mem_req=1 for the new fetch at Address=0 in the following cycle; rst overrides mem_ready.

Structure
REQ-028 Shared package risc_pkg: opcode constants, state encodings, status bit positions.
REQ-029 Sub-module risc_regfile: 2**REG_ADR_W x DATA_W, two async read ports, one sync write port, sync reset.

Verification
REQ-030 Reset, mem_ready=1: first fetch Address=0 one cycle after rst drop; status[7:5]=0.
REQ-031 Default params, R1=0x7FFF, R2=0x0001, ADD R3,R1,R2 -> R3=0x8000, N=1, Z=0, C=0, V=1, 3 cycles.
REQ-032 SUB R3,R2,R2 -> R3=0, Z=1, C=1; next JZ with M[PC]=0x0040 -> next fetch Address=0x0040.
REQ-033 LD with mem_ready low 3 cycles: Address/mw_en stable 4 cycles, W loads D_in on ready edge.
REQ-034 ST R1=0x0010, S=0xBEEF: mem_req=1, mw_en=1, Address=0x0010, D_out=0xBEEF; HALT next -> halted=1, no further mem_req.
REQ-035 DATA_W=32, ADDR_W=8: JMP at PC=0xFE -> operand fetched at 0xFF, PC wraps correctly; rst mid-MEM -> fetch at Address=0 next cycle.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the parameterised RISC core: opcodes, FSM state codes,
// status bit positions and small opcode classifiers.
package risc_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_JZ   = 4'hC;
  localparam logic [3:0] OP_JN   = 4'hD;
  localparam logic [3:0] OP_JC   = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  localparam int STAT_C         = 0;
  localparam int STAT_Z         = 1;
  localparam int STAT_N         = 2;
  localparam int STAT_V         = 3;
  localparam int STAT_REQ       = 4;
  localparam int STAT_STATE_LSB = 5;

  typedef struct packed {
    logic v;
    logic n;
    logic z;
    logic c;
  } flags_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

  function automatic logic is_cond_jump(input logic [3:0] op);
    return (op == OP_JZ) || (op == OP_JN) || (op == OP_JC);
  endfunction

endpackage

// File: rtl/risc_regfile.sv
// Register file: 2**REG_ADR_W words, two asynchronous read ports and one
// synchronous write port, cleared by synchronous reset.
module risc_regfile #(
  parameter int DATA_W    = 16,
  parameter int REG_ADR_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [REG_ADR_W-1:0] wa,
  input  logic [DATA_W-1:0]    wd,
  input  logic [REG_ADR_W-1:0] ra_a,
  output logic [DATA_W-1:0]    rd_a,
  input  logic [REG_ADR_W-1:0] ra_b,
  output logic [DATA_W-1:0]    rd_b
);

  localparam int NREGS = 2 ** REG_ADR_W;

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  assign rd_a = regs[ra_a];
  assign rd_b = regs[ra_b];

endmodule

// File: rtl/risc_core_param.sv
// Multi-cycle accumulator-free RISC core with a single request/ready memory port.
// state | meaning: FETCH read IR at PC; DECODE classify; EXEC ALU/untaken jump; MEM data/operand access; HALTED idle until rst
module risc_core_param
  import risc_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int REG_ADR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] D_in,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mw_en,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] D_out,
  output logic [7:0]        status,
  output logic              halted
);

  localparam int PAD_W = DATA_W - 4 - 3 * REG_ADR_W;

  logic [2:0]           state;
  logic [ADDR_W-1:0]    pc;
  logic [DATA_W-1:0]    ir;
  flags_t               flags;

  logic [3:0]           op;
  logic [REG_ADR_W-1:0] f_w;
  logic [REG_ADR_W-1:0] f_r;
  logic [REG_ADR_W-1:0] f_s;
  logic [DATA_W-1:0]    rd_r;
  logic [DATA_W-1:0]    rd_s;

  logic [DATA_W:0]      sum;
  logic [DATA_W:0]      diff;
  logic [DATA_W-1:0]    alu_res;
  logic                 alu_c;
  logic                 alu_v;
  flags_t               alu_flags;
  logic                 take_jump;
  logic                 data_op;
  logic                 rf_we;
  logic [DATA_W-1:0]    rf_wd;

  assign op  = ir[DATA_W-1 -: 4];
  assign f_w = ir[DATA_W-5 -: REG_ADR_W];
  assign f_r = ir[DATA_W-5-REG_ADR_W -: REG_ADR_W];
  assign f_s = ir[DATA_W-5-2*REG_ADR_W -: REG_ADR_W];

  generate
    if (PAD_W > 0) begin : g_pad
      logic unused_ir_pad;
      assign unused_ir_pad = ^ir[PAD_W-1:0];
    end
  endgenerate

  risc_regfile #(
    .DATA_W    (DATA_W),
    .REG_ADR_W (REG_ADR_W)
  ) u_regfile (
    .clk  (clk),
    .rst  (rst),
    .we   (rf_we),
    .wa   (f_w),
    .wd   (rf_wd),
    .ra_a (f_r),
    .rd_a (rd_r),
    .ra_b (f_s),
    .rd_b (rd_s)
  );

  always_comb begin
    sum     = {1'b0, rd_r} + {1'b0, rd_s};
    diff    = {1'b0, rd_r} - {1'b0, rd_s};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
        alu_v   = (rd_r[DATA_W-1] == rd_s[DATA_W-1]) && (alu_res[DATA_W-1] != rd_r[DATA_W-1]);
      end
      OP_SUB: begin
        // carry means "no borrow", i.e. R >= S unsigned
        alu_res = diff[DATA_W-1:0];
        alu_c   = ~diff[DATA_W];
        alu_v   = (rd_r[DATA_W-1] != rd_s[DATA_W-1]) && (alu_res[DATA_W-1] != rd_r[DATA_W-1]);
      end
      OP_AND: alu_res = rd_r & rd_s;
      OP_OR:  alu_res = rd_r | rd_s;
      OP_XOR: alu_res = rd_r ^ rd_s;
      OP_SHL: begin
        alu_res = {rd_s[DATA_W-2:0], 1'b0};
        alu_c   = rd_s[DATA_W-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, rd_s[DATA_W-1:1]};
        alu_c   = rd_s[0];
      end
      default: ;
    endcase
    alu_flags.v = alu_v;
    alu_flags.n = alu_res[DATA_W-1];
    alu_flags.z = (alu_res == '0);
    alu_flags.c = alu_c;
  end

  always_comb begin
    take_jump = 1'b0;
    case (op)
      OP_JMP:  take_jump = 1'b1;
      OP_JZ:   take_jump = flags.z;
      OP_JN:   take_jump = flags.n;
      OP_JC:   take_jump = flags.c;
      default: take_jump = 1'b0;
    endcase
  end

  // Request outputs depend only on state, IR and registers, so they hold steady during waits
  assign mem_req = (state == ST_FETCH) || (state == ST_MEM);
  assign data_op = (op == OP_LD) || (op == OP_ST);
  assign mw_en   = (state == ST_MEM) && (op == OP_ST);
  assign Address = ((state == ST_MEM) && data_op) ? ADDR_W'(rd_r) : pc;
  assign D_out   = rd_s;

  assign rf_we = ((state == ST_EXEC) && is_alu_op(op)) ||
                 ((state == ST_MEM) && mem_ready && ((op == OP_LD) || (op == OP_LDI)));
  assign rf_wd = (state == ST_EXEC) ? alu_res : D_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
      pc    <= '0;
      ir    <= '0;
      flags <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (mem_ready) begin
            ir    <= D_in;
            pc    <= pc + ADDR_W'(1);
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (op == OP_HALT)                 state <= ST_HALTED;
          else if (op <= OP_SHR)             state <= ST_EXEC;
          else if (op <= OP_LDI || take_jump) state <= ST_MEM;
          else                               state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (is_alu_op(op)) flags <= alu_flags;
          if (is_cond_jump(op)) pc <= pc + ADDR_W'(1);
          state <= ST_FETCH;
        end
        ST_MEM: begin
          if (mem_ready) begin
            if (op == OP_LDI)      pc <= pc + ADDR_W'(1);
            else if (op >= OP_JMP) pc <= ADDR_W'(D_in);
            state <= ST_FETCH;
          end
        end
        ST_HALTED: ;
        default: state <= ST_FETCH;
      endcase
    end
  end

  assign status = {state, mem_req, flags.v, flags.n, flags.z, flags.c};
  assign halted = (state == ST_HALTED);

endmodule

// File: tb/tb_risc_core_param.sv
// Bench for risc_core_param: an instruction-level reference model predicts every
// bus transaction and the flags seen at each fetch; a 32/8-bit instance covers PC wrap.
module tb_risc_core_param;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, mem_ready, mem_req, mw_en, halted;
  logic [15:0] D_in, Address, D_out;
  logic [7:0]  status;

  logic        rst32, rdy32, req32, mw32, halt32;
  logic [31:0] din32, dout32;
  logic [7:0]  addr32, stat32;

  risc_core_param u_dut (
    .clk       (clk),
    .rst       (rst),
    .D_in      (D_in),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mw_en     (mw_en),
    .Address   (Address),
    .D_out     (D_out),
    .status    (status),
    .halted    (halted)
  );

  risc_core_param #(.DATA_W(32), .ADDR_W(8), .REG_ADR_W(3)) u_dut32 (
    .clk       (clk),
    .rst       (rst32),
    .D_in      (din32),
    .mem_ready (rdy32),
    .mem_req   (req32),
    .mw_en     (mw32),
    .Address   (addr32),
    .D_out     (dout32),
    .status    (stat32),
    .halted    (halt32)
  );

  typedef struct {
    bit          fetch;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [3:0]  flags;
  } txn_t;

  logic [15:0] mem_tb  [65536];
  logic [15:0] mem_ref [65536];
  logic [31:0] mem32   [256];
  txn_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic [15:0] enc(input int op, input int w, input int r, input int s);
    return {op[3:0], w[2:0], r[2:0], s[2:0], 3'($urandom)};
  endfunction

  task automatic fill_mem_random();
    for (int i = 0; i < 65536; i++) mem_tb[i] = 16'($urandom);
  endtask

  // Architectural model: executes whole instructions and records the bus traffic they imply.
  task automatic iss_run();
    int regs[8];
    int pc, flags, ir, op, w, r, s, a, b, sa, sb, res, c, v, wide;
    bit done, taken;
    mem_ref = mem_tb;
    exp_q.delete();
    pc = 0; flags = 0; done = 0;
    for (int i = 0; i < 8; i++) regs[i] = 0;
    for (int k = 0; k < 2000 && !done; k++) begin
      exp_q.push_back('{1'b1, 1'b0, 16'(pc), 16'h0, 4'(flags)});
      ir = int'(mem_ref[pc]);
      pc = (pc + 1) % 65536;
      op = ir / 4096; w = (ir / 512) % 8; r = (ir / 64) % 8; s = (ir / 8) % 8;
      a = regs[r]; b = regs[s];
      sa = (a >= 32768) ? a - 65536 : a;
      sb = (b >= 32768) ? b - 65536 : b;
      if (op >= 1 && op <= 7) begin
        c = 0; v = 0; res = 0;
        case (op)
          1: begin wide = a + b; res = wide % 65536; c = int'(wide > 65535);
                   v = int'((sa + sb > 32767) || (sa + sb < -32768)); end
          2: begin res = (a - b + 65536) % 65536; c = int'(a >= b);
                   v = int'((sa - sb > 32767) || (sa - sb < -32768)); end
          3: res = a & b;
          4: res = a | b;
          5: res = a ^ b;
          6: begin res = (b * 2) % 65536; c = int'(b >= 32768); end
          7: begin res = b / 2; c = b % 2; end
          default: ;
        endcase
        regs[w] = res;
        flags = v * 8 + int'(res >= 32768) * 4 + int'(res == 0) * 2 + c;
      end else begin
        case (op)
          8: begin exp_q.push_back('{1'b0, 1'b0, 16'(a), 16'h0, 4'h0}); regs[w] = int'(mem_ref[a]); end
          9: begin exp_q.push_back('{1'b0, 1'b1, 16'(a), 16'(b), 4'h0}); mem_ref[a] = 16'(b); end
          10: begin
            exp_q.push_back('{1'b0, 1'b0, 16'(pc), 16'h0, 4'h0});
            regs[w] = int'(mem_ref[pc]);
            pc = (pc + 1) % 65536;
          end
          11, 12, 13, 14: begin
            taken = (op == 11) || (op == 12 && flags[1]) || (op == 13 && flags[2]) || (op == 14 && flags[0]);
            if (taken) begin
              exp_q.push_back('{1'b0, 1'b0, 16'(pc), 16'h0, 4'h0});
              pc = int'(mem_ref[pc]);
            end else begin
              pc = (pc + 1) % 65536;
            end
          end
          15: done = 1;
          default: ;
        endcase
      end
    end
  endtask

  // mode 0: ready always high; 1: random ready; 2: three wait cycles on every request
  task automatic run_dut(input int mode, input string tag);
    txn_t        e;
    int          last_fetch, waitcnt;
    bit          prev_wait, rdy;
    logic [15:0] p_addr, p_dout;
    logic        p_we;
    last_fetch = -1; waitcnt = 0; prev_wait = 0; p_addr = '0; p_dout = '0; p_we = 1'b0;
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 20000 && exp_q.size() > 0; cyc++) begin
      if (mem_req) begin
        if (prev_wait) begin
          n_tests++;
          if (Address !== p_addr || mw_en !== p_we || (p_we && D_out !== p_dout)) begin
            n_fail++;
            $display("FAIL %s stable: addr=%h we=%b dout=%h, required addr=%h we=%b dout=%h",
                     tag, Address, mw_en, D_out, p_addr, p_we, p_dout);
          end
        end
        case (mode)
          0: rdy = 1'b1;
          1: rdy = ($urandom_range(0, 99) < 65);
          default: rdy = (waitcnt == 3);
        endcase
        waitcnt = rdy ? 0 : waitcnt + 1;
        if (rdy) begin
          e = exp_q.pop_front();
          n_tests++;
          if ((status[7:5] == 3'd0) !== e.fetch || mw_en !== e.we || Address !== e.addr ||
              (e.we && D_out !== e.wdata)) begin
            n_fail++;
            $display("FAIL %s txn: fetch=%b we=%b addr=%h dout=%h, required fetch=%b we=%b addr=%h dout=%h",
                     tag, (status[7:5] == 3'd0), mw_en, Address, D_out, e.fetch, e.we, e.addr, e.wdata);
          end
          if (e.fetch) begin
            n_tests++;
            if (status[3:0] !== e.flags) begin
              n_fail++;
              $display("FAIL %s flags at fetch %h: got %b, required %b", tag, e.addr, status[3:0], e.flags);
            end
            if (mode == 0 && last_fetch >= 0) begin
              n_tests++;
              if (cyc - last_fetch != 3) begin
                n_fail++;
                $display("FAIL %s cycles: instruction took %0d, required 3", tag, cyc - last_fetch);
              end
            end
            last_fetch = cyc;
          end
          if (mw_en) mem_tb[Address] = D_out;
          D_in = mem_tb[Address];
        end else begin
          D_in = 16'($urandom);
        end
        mem_ready = rdy;
        prev_wait = !rdy;
        p_addr = Address; p_we = mw_en; p_dout = D_out;
      end else begin
        mem_ready = 1'($urandom);
        D_in = 16'($urandom);
        prev_wait = 0;
        waitcnt = 0;
      end
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout: %0d transactions outstanding, required 0", tag, exp_q.size());
    end else begin
      mem_ready = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (halted !== 1'b1 || mem_req !== 1'b0 || status[7:5] !== 3'd4) begin
          n_fail++;
          $display("FAIL %s halt: halted=%b mem_req=%b state=%0d, required 1 0 4", tag, halted, mem_req, status[7:5]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_add_sub_jz();
    fill_mem_random();
    mem_tb[0] = enc(10, 1, 0, 0); mem_tb[1] = 16'h7FFF;
    mem_tb[2] = enc(10, 2, 0, 0); mem_tb[3] = 16'h0001;
    mem_tb[4] = enc(1, 3, 1, 2);
    mem_tb[5] = enc(9, 0, 0, 3);
    mem_tb[6] = enc(2, 3, 2, 2);
    mem_tb[7] = enc(12, 0, 0, 0); mem_tb[8] = 16'h0040;
    mem_tb[16'h40] = enc(9, 0, 0, 3);
    mem_tb[16'h41] = enc(15, 0, 0, 0);
    iss_run();
    run_dut(0, "add_sub_jz");
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (status !== 8'h10 || mem_req !== 1'b1 || Address !== 16'h0 || mw_en !== 1'b0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: status=%h req=%b addr=%h we=%b halted=%b, required 10 1 0000 0 0",
               status, mem_req, Address, mw_en, halted);
    end
  endtask

  task automatic test_store_halt();
    fill_mem_random();
    mem_tb[0] = enc(10, 1, 0, 0); mem_tb[1] = 16'h0010;
    mem_tb[2] = enc(10, 2, 0, 0); mem_tb[3] = 16'hBEEF;
    mem_tb[4] = enc(9, 0, 1, 2);
    mem_tb[5] = enc(15, 0, 0, 0);
    iss_run();
    run_dut(1, "store_halt");
  endtask

  task automatic test_ld_wait();
    fill_mem_random();
    mem_tb[0] = enc(10, 1, 0, 0); mem_tb[1] = 16'h0100;
    mem_tb[2] = enc(8, 4, 1, 0);
    mem_tb[3] = enc(9, 0, 0, 4);
    mem_tb[4] = enc(15, 0, 0, 0);
    mem_tb[16'h100] = 16'h1234;
    iss_run();
    run_dut(2, "ld_wait");
  endtask

  task automatic gen_random_prog(input int n);
    int p, k, rr;
    logic [15:0] imm;
    p = 0;
    fill_mem_random();
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 9);
      if (k <= 4 || k == 9) begin
        mem_tb[p] = enc($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        p = p + 1;
      end else if (k == 5) begin
        case ($urandom_range(0, 5))
          0: imm = 16'h7FFF;
          1: imm = 16'h8000;
          2: imm = 16'hFFFF;
          3: imm = 16'h0000;
          4: imm = 16'h0001;
          default: imm = 16'($urandom);
        endcase
        mem_tb[p] = enc(10, $urandom_range(0, 7), 0, 0); mem_tb[p+1] = imm;
        p = p + 2;
      end else if (k == 6) begin
        mem_tb[p] = enc(8, $urandom_range(0, 7), $urandom_range(0, 7), 0);
        p = p + 1;
      end else if (k == 7) begin
        rr = $urandom_range(0, 7);
        mem_tb[p] = enc(10, rr, 0, 0);
        mem_tb[p+1] = 16'($urandom_range(16'h1000, 16'hFFFF));
        mem_tb[p+2] = enc(9, $urandom_range(0, 7), rr, $urandom_range(0, 7));
        p = p + 3;
      end else begin
        mem_tb[p] = enc($urandom_range(11, 14), 0, 0, 0);
        mem_tb[p+1] = 16'(p + 3);
        mem_tb[p+2] = enc($urandom_range(1, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        p = p + 3;
      end
    end
    mem_tb[p] = enc(15, 0, 0, 0);
  endtask

  task automatic test_random();
    int modes[6] = '{0, 1, 1, 2, 0, 1};
    for (int t = 0; t < 6; t++) begin
      gen_random_prog(40);
      iss_run();
      run_dut(modes[t], $sformatf("random%0d", t));
    end
  endtask

  task automatic test_wrap32();
    int exp32[8] = '{0, 1, 'hFE, 'hFF, 'h20, 'h21, 'hFF, 0};
    int idx, guard;
    for (int i = 0; i < 256; i++) mem32[i] = $urandom;
    mem32[8'h00] = {4'hB, 28'($urandom)};
    mem32[8'h01] = {24'($urandom), 8'hFE};
    mem32[8'hFE] = {4'hB, 28'($urandom)};
    mem32[8'hFF] = {4'h0, 20'($urandom), 8'h20};
    mem32[8'h20] = {4'hB, 28'($urandom)};
    mem32[8'h21] = {24'($urandom), 8'hFF};
    @(negedge clk);
    rst32 = 1'b1; rdy32 = 1'b1;
    @(negedge clk);
    rst32 = 1'b0;
    idx = 0;
    for (guard = 0; guard < 60 && idx < 8; guard++) begin
      if (req32) begin
        n_tests++;
        if (int'(addr32) != exp32[idx]) begin
          n_fail++;
          $display("FAIL wrap32 addr[%0d]: got %h, required %h", idx, addr32, exp32[idx]);
        end
        idx++;
      end
      din32 = mem32[addr32];
      @(negedge clk);
    end
    for (guard = 0; guard < 10 && !(req32 && stat32[7:5] == 3'd3); guard++) @(negedge clk);
    n_tests++;
    if (!(req32 && stat32[7:5] == 3'd3) || addr32 !== 8'h01) begin
      n_fail++;
      $display("FAIL wrap32 mem: req=%b state=%0d addr=%h, required 1 3 01", req32, stat32[7:5], addr32);
    end
    rst32 = 1'b1; rdy32 = 1'b1; din32 = mem32[8'h01];
    @(negedge clk);
    rst32 = 1'b0;
    n_tests++;
    if (stat32[7:5] !== 3'd0 || req32 !== 1'b1 || addr32 !== 8'h00) begin
      n_fail++;
      $display("FAIL wrap32 rst_mid_mem: state=%0d req=%b addr=%h, required 0 1 00", stat32[7:5], req32, addr32);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_ready = 1'b0; D_in = '0;
    rst32 = 1'b1; rdy32 = 1'b0; din32 = '0;
    test_add_sub_jz();
    test_reset();
    test_store_halt();
    test_ld_wait();
    test_random();
    test_wrap32();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
